// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline: per-cycle register enables, bubbles, PC control, stall watchdog.
// Optional per-rule cycle counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int unsigned TIMEOUT_W = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_valid,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd,
   input  logic       ex_mispredict,
   input  logic       imem_read,
   input  logic       imem_resp,
   input  logic       dmem_req,
   input  logic       dmem_resp,
   output logic       pc_load,
   output logic       pc_redirect,
   output logic       load_if_id,
   output logic       load_id_ex,
   output logic       load_ex_mem,
   output logic       load_mem_wb,
   output logic       bubble_if_id,
   output logic       bubble_id_ex,
   output logic       hang_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_dstall_cnt,
   output logic [31:0] perf_istall_cnt,
   output logic [31:0] perf_lu_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DSTALL,
      ST_ISTALL
   } state_t;

   typedef enum logic [2:0] {
      RULE_DSTALL,
      RULE_FLUSH,
      RULE_FLUSH_PEND,
      RULE_REDIRECT,
      RULE_ISTALL,
      RULE_LOAD_USE,
      RULE_RUN
   } rule_t;

   localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

   state_t                r_state;
   state_t                w_state_next;
   rule_t                 w_rule;
   logic                  r_redirect_pend;
   logic                  w_redirect_pend_next;
   logic [TIMEOUT_W-1:0]  r_wd_cnt;
   logic                  r_hang_err;

   logic w_dstall;
   logic w_istall;
   logic w_mp;
   logic w_lu;

   always_comb begin
      w_dstall = dmem_req && !dmem_resp;
      w_istall = imem_read && !imem_resp;
      w_mp     = ex_valid && ex_mispredict;
      w_lu     = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
   end

   always_comb begin
      w_rule = RULE_RUN;
      if (w_dstall)                         w_rule = RULE_DSTALL;
      else if (w_mp && !w_istall)           w_rule = RULE_FLUSH;
      else if (w_mp)                        w_rule = RULE_FLUSH_PEND;
      else if (r_redirect_pend && imem_resp) w_rule = RULE_REDIRECT;
      else if (w_istall)                    w_rule = RULE_ISTALL;
      else if (w_lu)                        w_rule = RULE_LOAD_USE;
   end

   always_comb begin
      pc_load      = 1'b0;
      pc_redirect  = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      bubble_if_id = 1'b0;
      bubble_id_ex = 1'b0;
      unique case (w_rule)
         RULE_DSTALL: ;
         // Deferred redirect also squashes ID: IF/ID still holds the old-path instruction.
         RULE_FLUSH, RULE_REDIRECT: begin
            pc_load      = 1'b1;
            pc_redirect  = 1'b1;
            load_if_id   = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            bubble_if_id = 1'b1;
            bubble_id_ex = 1'b1;
         end
         RULE_FLUSH_PEND, RULE_ISTALL, RULE_LOAD_USE: begin
            load_id_ex   = 1'b1;
            bubble_id_ex = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
         end
         RULE_RUN: begin
            pc_load      = 1'b1;
            load_if_id   = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_RUN: begin
            if (w_dstall)      w_state_next = ST_DSTALL;
            else if (w_istall) w_state_next = ST_ISTALL;
         end
         ST_DSTALL: begin
            if (dmem_resp) w_state_next = ST_RUN;
         end
         ST_ISTALL: begin
            if (w_dstall)       w_state_next = ST_DSTALL;
            else if (imem_resp) w_state_next = ST_RUN;
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   // An immediate redirect also ends any pending one: no stale fetch remains outstanding.
   always_comb begin
      w_redirect_pend_next = r_redirect_pend;
      if (w_rule == RULE_FLUSH_PEND)
         w_redirect_pend_next = 1'b1;
      else if ((w_rule == RULE_FLUSH) || (w_rule == RULE_REDIRECT))
         w_redirect_pend_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_RUN;
         r_redirect_pend <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_redirect_pend <= w_redirect_pend_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd_cnt   <= '0;
         r_hang_err <= 1'b0;
      end else if (r_state == ST_RUN) begin
         r_wd_cnt <= '0;
      end else begin
         if (r_wd_cnt != WD_MAX)
            r_wd_cnt <= r_wd_cnt + 1'b1;
         if (r_wd_cnt == (WD_MAX - 1'b1))
            r_hang_err <= 1'b1;
      end
   end

   assign hang_err = r_hang_err;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] r_perf_dstall;
   logic [31:0] r_perf_istall;
   logic [31:0] r_perf_lu;
   logic [31:0] r_perf_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_dstall <= '0;
         r_perf_istall <= '0;
         r_perf_lu     <= '0;
         r_perf_flush  <= '0;
      end else begin
         if (w_rule == RULE_DSTALL)   r_perf_dstall <= r_perf_dstall + 32'd1;
         if (w_rule == RULE_ISTALL)   r_perf_istall <= r_perf_istall + 32'd1;
         if (w_rule == RULE_LOAD_USE) r_perf_lu     <= r_perf_lu + 32'd1;
         if ((w_rule == RULE_FLUSH) || (w_rule == RULE_FLUSH_PEND) || (w_rule == RULE_REDIRECT))
            r_perf_flush <= r_perf_flush + 32'd1;
      end
   end

   assign perf_dstall_cnt = r_perf_dstall;
   assign perf_istall_cnt = r_perf_istall;
   assign perf_lu_cnt     = r_perf_lu;
   assign perf_flush_cnt  = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a rule-table reference model.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned TW = 4;
   localparam int HANG_LIMIT = (1 << TW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       id_valid, id_uses_rs1, id_uses_rs2;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       ex_valid, ex_is_load, ex_mispredict;
   logic       imem_read, imem_resp, dmem_req, dmem_resp;
   logic       pc_load, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic       bubble_if_id, bubble_id_ex, hang_err;

   pipeline_hazard_ctrl #(.TIMEOUT_W(TW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_mispredict(ex_mispredict),
      .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
      .pc_load(pc_load), .pc_redirect(pc_redirect),
      .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
      .bubble_if_id(bubble_if_id), .bubble_id_ex(bubble_id_ex), .hang_err(hang_err)
   );

   typedef enum {M_RUN, M_DWAIT, M_IWAIT} mmode_t;
   mmode_t m_mode;
   bit     m_pend, m_hang;
   int     m_stall_len;
   int     n_assert = 0;
   int     n_fail = 0;
   string  tag;

   // Which priority rule (1..7) applies to the current inputs.
   function automatic int pick_rule();
      bit dst, ist, mp, lu;
      dst = dmem_req && !dmem_resp;
      ist = imem_read && !imem_resp;
      mp  = ex_valid && ex_mispredict;
      lu  = ex_valid && ex_is_load && (ex_rd != 0) && id_valid &&
            ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (dst) return 1;
      if (mp && !ist) return 2;
      if (mp) return 3;
      if (m_pend && imem_resp) return 4;
      if (ist) return 5;
      if (lu) return 6;
      return 7;
   endfunction

   // {pc_load, pc_redirect, if_id, id_ex, ex_mem, mem_wb, bubble_if_id, bubble_id_ex}
   function automatic logic [7:0] rule_outputs(int r);
      case (r)
         1:       return 8'b0000_0000;
         2, 4:    return 8'b1111_1111;
         3, 5, 6: return 8'b0001_1101;
         default: return 8'b1011_1100;
      endcase
   endfunction

   task automatic set_idle();
      rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_mispredict = 0;
      imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
   endtask

   task automatic model_reset();
      m_mode = M_RUN; m_pend = 0; m_hang = 0; m_stall_len = 0;
   endtask

   // Inputs are already applied just after a falling edge; check, advance model, move to next falling edge.
   task automatic step();
      int r;
      logic [7:0] exp_v, obs_v;
      bit dst, ist;
      #2;
      r = pick_rule();
      exp_v = rule_outputs(r);
      obs_v = {pc_load, pc_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble_if_id, bubble_id_ex};
      n_assert++;
      assert (obs_v === exp_v) else begin
         n_fail++;
         $error("FAIL %s outputs: observed %b expected %b (rule %0d)", tag, obs_v, exp_v, r);
      end
      n_assert++;
      assert (hang_err === m_hang) else begin
         n_fail++;
         $error("FAIL %s hang_err: observed %b expected %b", tag, hang_err, m_hang);
      end
      if (rst) begin
         model_reset();
      end else begin
         dst = dmem_req && !dmem_resp;
         ist = imem_read && !imem_resp;
         if (r == 3) m_pend = 1;
         else if (r == 2 || r == 4) m_pend = 0;
         if (m_mode != M_RUN) begin
            m_stall_len++;
            if (m_stall_len >= HANG_LIMIT) m_hang = 1;
         end else begin
            m_stall_len = 0;
         end
         case (m_mode)
            M_RUN:   if (dst) m_mode = M_DWAIT; else if (ist) m_mode = M_IWAIT;
            M_DWAIT: if (dmem_resp) m_mode = M_RUN;
            default: if (dst) m_mode = M_DWAIT; else if (imem_resp) m_mode = M_RUN;
         endcase
      end
      @(negedge clk);
   endtask

   initial begin
      set_idle();
      rst = 1;
      tag = "reset";
      @(negedge clk);
      model_reset();
      step();
      set_idle();
      step();

      tag = "load_use";
      ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5; id_rs2 = 1;
      step();
      tag = "load_use_after";
      ex_valid = 0; ex_is_load = 0;
      step();

      tag = "load_x0";
      ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
      step();
      set_idle();

      tag = "dstall";
      dmem_req = 1;
      for (int i = 0; i < 7; i++) step();
      tag = "dstall_resp";
      dmem_resp = 1;
      step();
      set_idle();
      step();

      tag = "mp_istall";
      ex_valid = 1; ex_mispredict = 1; imem_read = 1;
      step();
      ex_valid = 0; ex_mispredict = 0;
      step();
      step();
      tag = "mp_redirect";
      imem_resp = 1;
      step();
      tag = "mp_after";
      imem_read = 0; imem_resp = 0;
      step();
      tag = "mp_after_resp";
      imem_read = 1; imem_resp = 1;
      step();
      set_idle();

      tag = "mp_dstall";
      ex_valid = 1; ex_mispredict = 1; dmem_req = 1;
      for (int i = 0; i < 3; i++) step();
      tag = "mp_dstall_resp";
      dmem_resp = 1;
      step();
      set_idle();
      step();

      tag = "watchdog";
      dmem_req = 1;
      for (int i = 0; i < 20; i++) step();
      tag = "watchdog_sticky";
      dmem_resp = 1;
      step();
      set_idle();
      for (int i = 0; i < 3; i++) step();
      tag = "watchdog_rst";
      rst = 1;
      step();
      rst = 0;
      step();

      tag = "random";
      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom_range(0, 79) == 0);
         id_valid    = $urandom_range(0, 1);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_uses_rs1 = $urandom_range(0, 1);
         id_uses_rs2 = $urandom_range(0, 1);
         ex_valid    = $urandom_range(0, 1);
         ex_is_load  = $urandom_range(0, 1);
         ex_rd       = 5'($urandom_range(0, 3));
         ex_mispredict = !m_pend && ($urandom_range(0, 5) == 0);
         imem_read   = $urandom_range(0, 1);
         imem_resp   = imem_read && ($urandom_range(0, 2) == 0);
         dmem_req    = ($urandom_range(0, 3) == 0) || (m_mode == M_DWAIT && $urandom_range(0, 7) != 0);
         dmem_resp   = dmem_req && ($urandom_range(0, 2) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage rv32i pipeline (IF, ID, EX, MEM, WB).
- Decides each cycle which inter-stage registers load, which take a bubble, and whether the PC advances.
- Covers I-cache misses, D-cache misses, load-use hazards (ID forwards from MEM, so one bubble suffices) and branch/jump mispredict redirects.
- Tracks a redirect that arrives while a fetch is outstanding, so the stale fetched instruction is discarded.

Parameters:
- TIMEOUT_W, 10, width of the stall watchdog counter; timeout fires at 2^TIMEOUT_W-1 consecutive stalled cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs1, id_rs2  in  5 each  source registers decoded in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2
- ex_valid  in  1  ID/EX holds a valid instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_mispredict  in  1  EX resolved a taken branch/jump differing from the fetched path
- imem_read  in  1  IF has an I-cache request outstanding
- imem_resp  in  1  I-cache response this cycle
- dmem_req  in  1  MEM stage has a D-cache read or write outstanding
- dmem_resp  in  1  D-cache response this cycle
- pc_load  out  1  PC register updates
- pc_redirect  out  1  PC selects the EX target (valid only with pc_load)
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipeline register enables
- bubble_if_id, bubble_id_ex  out  1 each  clear the valid bit of the register on load
- hang_err  out  1  sticky watchdog error

Behaviour:
- Reset values: state RUN, redirect_pend 0, watchdog 0, hang_err 0.
- All enables and bubbles are combinational from state and inputs; no added latency.
- Definitions:
  - dstall = dmem_req && !dmem_resp
  - istall = imem_read && !imem_resp
  - mp = ex_valid && ex_mispredict
  - lu = ex_valid && ex_is_load && ex_rd!=0 && id_valid && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd))
- Cycle priority, highest first:
  1. dstall: every load_* = 0, pc_load = 0; whole pipe frozen; mp is not consumed.
  2. mp && !istall: all loads 1, pc_load 1, pc_redirect 1, bubble_if_id 1, bubble_id_ex 1.
  3. mp && istall: load_ex_mem and load_mem_wb = 1; bubble_id_ex 1 with load_id_ex 1; pc_load 0, load_if_id 0. Set redirect_pend.
  4. redirect_pend && imem_resp: discard the returned instruction (load_if_id 1, bubble_if_id 1); pc_load 1, pc_redirect 1; clear redirect_pend. EX must hold the target through a registered copy outside this block. pc_redirect here uses the target latched at step 3.
  5. istall: pc_load 0, load_if_id 0, load_id_ex 1 with bubble_id_ex 1, EX/MEM and MEM/WB load 1.
  6. lu: same as istall for exactly one cycle; on the next cycle the load is in MEM and the hazard condition is false.
  7. Otherwise: all loads 1, pc_load 1, no bubbles.
- State register, for observability and watchdog:
  - RUN -> DSTALL on dstall.
  - RUN -> ISTALL on istall.
  - DSTALL -> RUN on dmem_resp.
  - ISTALL -> RUN on imem_resp.
  - ISTALL -> DSTALL if dstall arises.
  - redirect_pend is orthogonal to state.
- Watchdog:
  - Increments every cycle in DSTALL or ISTALL; clears in RUN.
  - Saturating at all-ones sets hang_err, which stays 1 until rst.
- Simultaneous dmem_resp and imem_resp: both resolve in the same cycle and state returns to RUN.
- lu and mp together: mp wins; the ID instruction is squashed anyway.
- Reset mid-stall: all state clears next edge; outputs revert to step-7 values unless inputs say otherwise.

Optional Feature:
- HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_dstall_cnt, perf_istall_cnt, perf_lu_cnt and perf_flush_cnt (32 bits each).
  - Each counts cycles where its priority rule fired: dstall, istall, lu, and mp/redirect respectively.
  - Counters wrap modulo 2^32 and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- lw x5 in EX, add x6,x5,x1 in ID (id_rs1=5) -> one cycle with pc_load 0, load_if_id 0, bubble_id_ex 1; next cycle all loads 1.
- ex_rd=0 with a load and id_rs1=0 -> no stall, all loads 1.
- dmem_req=1, dmem_resp low for 7 cycles -> all loads 0 for 7 cycles, state DSTALL; 8th cycle with resp=1 -> loads 1, state RUN.
- mp while imem_read=1 and imem_resp=0 for 3 cycles -> redirect_pend=1; on the response cycle bubble_if_id 1, pc_redirect 1; redirect_pend then 0.
- mp with dstall -> no redirect until dmem_resp; redirect fires in the response cycle.
- TIMEOUT_W=4, dmem never responds -> hang_err 1 after 15 stalled cycles and remains 1 after dmem_resp; cleared only by rst=1.
